// File: rtl/tdm_demux.sv
// ----------------------------------------------------------------------------
// tdm_demux
//   Splits a serial 4-slot TDM sample stream into four parallel outputs.
//   A frame_sync-marked sample acquires alignment (HUNT -> LOCKED). Slots 0..2
//   are held in shadow registers. On the slot-3 sample the whole frame is
//   published to out0..out3 and frame_valid pulses for one cycle.
//   A frame_sync seen away from slot 0 pulses sync_err, drops the partial
//   frame and restarts capture with that sample as slot 0.
//
// Ports
//   clk         : clock, rising edge
//   rst         : asynchronous reset, active low
//   in          : TDM sample, WIDTH bits, valid when en=1
//   en          : sample strobe
//   frame_sync  : current sample is slot 0 (valid when en=1)
//   out0..out3  : last complete frame, slots 0..3
//   frame_valid : one-cycle pulse when out0..out3 are updated
//   slot        : slot index expected for the next enabled sample
//   locked      : frame alignment acquired
//   sync_err    : one-cycle pulse on a misplaced frame_sync
// ----------------------------------------------------------------------------
module tdm_demux #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             en,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic             frame_valid,
    output logic [1:0]       slot,
    output logic             locked,
    output logic             sync_err
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [1:0]       slot_reg, slot_next;
    logic [WIDTH-1:0] shadow_reg [0:2];
    logic [WIDTH-1:0] shadow_next [0:2];
    logic [WIDTH-1:0] out_reg [0:3];
    logic [WIDTH-1:0] out_next [0:3];
    logic             frame_valid_reg, frame_valid_next;
    logic             sync_err_reg, sync_err_next;

    // State, slot index and the single-cycle pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= HUNT;
            slot_reg        <= 2'd0;
            frame_valid_reg <= 1'b0;
            sync_err_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            slot_reg        <= slot_next;
            frame_valid_reg <= frame_valid_next;
            sync_err_reg    <= sync_err_next;
        end
    end

    // Shadow registers for slots 0..2 (slot 3 goes straight to out3)
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_shadow
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    shadow_reg[gi] <= '0;
                end else begin
                    shadow_reg[gi] <= shadow_next[gi];
                end
            end
        end

        for (gi = 0; gi < 4; gi++) begin : g_out
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    out_reg[gi] <= '0;
                end else begin
                    out_reg[gi] <= out_next[gi];
                end
            end
        end
    endgenerate

    always_comb begin
        state_next       = state_reg;
        slot_next        = slot_reg;
        frame_valid_next = 1'b0;
        sync_err_next    = 1'b0;
        for (int i = 0; i < 3; i++) shadow_next[i] = shadow_reg[i];
        for (int i = 0; i < 4; i++) out_next[i] = out_reg[i];

        if (en) begin
            case (state_reg)
                HUNT: begin
                    // Samples without frame_sync carry no alignment and are dropped
                    if (frame_sync) begin
                        shadow_next[0] = in;
                        slot_next      = 2'd1;
                        state_next     = LOCKED;
                    end
                end
                LOCKED: begin
                    if (frame_sync && (slot_reg != 2'd0)) begin
                        // Misplaced sync: abandon the partial frame, realign here
                        sync_err_next  = 1'b1;
                        shadow_next[0] = in;
                        slot_next      = 2'd1;
                    end else if (slot_reg == 2'd3) begin
                        // Frame complete: publish shadows plus the live slot-3 sample
                        for (int i = 0; i < 3; i++) out_next[i] = shadow_reg[i];
                        out_next[3]      = in;
                        frame_valid_next = 1'b1;
                        slot_next        = 2'd0;
                    end else begin
                        for (int i = 0; i < 3; i++) begin
                            if (slot_reg == 2'(i)) shadow_next[i] = in;
                        end
                        slot_next = slot_reg + 2'd1;
                    end
                end
                default: state_next = HUNT;
            endcase
        end
    end

    assign out0        = out_reg[0];
    assign out1        = out_reg[1];
    assign out2        = out_reg[2];
    assign out3        = out_reg[3];
    assign frame_valid = frame_valid_reg;
    assign sync_err    = sync_err_reg;
    assign slot        = slot_reg;
    assign locked      = (state_reg == LOCKED);

endmodule
